// File: rtl/debug_uart_frame_rx.sv
// debug_uart_frame_rx: 8N1 UART receiver with a BE EF framed calibration payload parser.
// Presents four input and four output channels, each sign-extended to W, with a frame strobe.
module debug_uart_frame_rx #(
  parameter int unsigned W   = 16,
  parameter int unsigned DIV = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_i,
  output logic signed [W-1:0] in0,
  output logic signed [W-1:0] in1,
  output logic signed [W-1:0] in2,
  output logic signed [W-1:0] in3,
  output logic signed [W-1:0] out0,
  output logic signed [W-1:0] out1,
  output logic signed [W-1:0] out2,
  output logic signed [W-1:0] out3,
  output logic                frame_valid,
  output logic [7:0]          byte_o,
  output logic                byte_valid,
  output logic [7:0]          err_count
);

  localparam int unsigned   TW       = $clog2(DIV);
  localparam logic [TW-1:0] HalfLast = TW'(DIV / 2 - 1);
  localparam logic [TW-1:0] FullLast = TW'(DIV - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {Hunt1, Hunt2, Payload} parse_state_e;

  logic          sync1, sync2;
  rx_state_e     rx_state, rx_state_next;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          tick, start_det, start_ok, data_tick, stop_ok, frame_err;

  parse_state_e  p_state, p_state_next;
  logic [3:0]    idx;
  logic [7:0]    shadow [16];
  logic          frame_done;

  function automatic logic signed [W-1:0] sext(input logic [7:0] hi, input logic [7:0] lo);
    logic signed [15:0] v;
    v = {hi, lo};
    return W'(v);
  endfunction

  // Two-flop synchroniser, both flops reset high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx_i;
      sync2 <= sync1;
    end
  end

  // Sample point: half a bit into the start bit, then every full bit after it
  always_comb begin
    tick = 1'b0;
    if (rx_state == RxStart) begin
      tick = (timer == HalfLast);
    end else if (rx_state != RxIdle) begin
      tick = (timer == FullLast);
    end
  end

  // Bit receiver state register
  always_ff @(posedge clk) begin
    if (rst) rx_state <= RxIdle;
    else     rx_state <= rx_state_next;
  end

  // Bit receiver next-state logic
  always_comb begin
    rx_state_next = rx_state;
    unique case (rx_state)
      RxIdle:  if (!sync2) rx_state_next = RxStart;
      RxStart: if (tick) rx_state_next = sync2 ? RxIdle : RxData;
      RxData:  if (tick && bit_cnt == 3'd7) rx_state_next = RxStop;
      RxStop:  if (tick) rx_state_next = RxIdle;
      default: rx_state_next = RxIdle;
    endcase
  end

  // Bit receiver decoded strobes
  always_comb begin
    start_det = (rx_state == RxIdle) && !sync2;
    start_ok  = (rx_state == RxStart) && tick && !sync2;
    data_tick = (rx_state == RxData) && tick;
    stop_ok   = (rx_state == RxStop) && tick && sync2;
    frame_err = (rx_state == RxStop) && tick && !sync2;
  end

  // Bit timer, shift register, byte output and saturating error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      timer      <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      byte_o     <= '0;
      byte_valid <= 1'b0;
      err_count  <= '0;
    end else begin
      byte_valid <= stop_ok;
      if (start_det || tick) begin
        timer <= '0;
      end else if (rx_state != RxIdle) begin
        timer <= timer + TW'(1);
      end
      if (start_ok) bit_cnt <= '0;
      if (data_tick) begin
        shift   <= {sync2, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (stop_ok) byte_o <= shift;
      if (frame_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  // Frame parser state register
  always_ff @(posedge clk) begin
    if (rst) p_state <= Hunt1;
    else     p_state <= p_state_next;
  end

  // Frame parser next-state logic; a framing error always drops back to hunting
  always_comb begin
    p_state_next = p_state;
    if (frame_err) begin
      p_state_next = Hunt1;
    end else if (byte_valid) begin
      unique case (p_state)
        Hunt1:   if (byte_o == 8'hBE) p_state_next = Hunt2;
        Hunt2: begin
          if (byte_o == 8'hEF)      p_state_next = Payload;
          else if (byte_o != 8'hBE) p_state_next = Hunt1;
        end
        Payload: if (idx == 4'd15) p_state_next = Hunt1;
        default: p_state_next = Hunt1;
      endcase
    end
  end

  // Frame parser decoded completion strobe
  always_comb begin
    frame_done = byte_valid && !frame_err && (p_state == Payload) && (idx == 4'd15);
  end

  // Payload index; wraps to 0 after byte 15 and is cleared by an abort
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (frame_err) begin
      idx <= '0;
    end else if (byte_valid && p_state == Payload) begin
      idx <= idx + 4'd1;
    end
  end

  // Shadow buffer holding the partial payload
  always_ff @(posedge clk) begin
    if (byte_valid && p_state == Payload) shadow[idx] <= byte_o;
  end

  // Channel outputs, only updated when a whole payload has arrived
  always_ff @(posedge clk) begin
    if (rst) begin
      in0         <= '0;
      in1         <= '0;
      in2         <= '0;
      in3         <= '0;
      out0        <= '0;
      out1        <= '0;
      out2        <= '0;
      out3        <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= frame_done;
      if (frame_done) begin
        in0  <= sext(shadow[0], shadow[1]);
        in1  <= sext(shadow[2], shadow[3]);
        in2  <= sext(shadow[4], shadow[5]);
        in3  <= sext(shadow[6], shadow[7]);
        out0 <= sext(shadow[8], shadow[9]);
        out1 <= sext(shadow[10], shadow[11]);
        out2 <= sext(shadow[12], shadow[13]);
        out3 <= sext(shadow[14], byte_o);
      end
    end
  end

endmodule

// File: doc/debug_uart_frame_rx.md
# debug_uart_frame_rx

Receive-side counterpart of the calibration debug UART link. It deserialises an 8N1 UART stream, locks onto the 0xBE 0xEF frame marker and collects the 16 payload bytes that follow. It then presents eight signed channel values (four inputs, four outputs) with a one-cycle frame strobe. It sits in loopback and self-test builds, and in host-bridge bringup builds, wherever a board must consume calibration frames produced by the debug transmitter.

## Interface
- W, 16: channel output width; must be ≥ 16; received 16-bit values are sign-extended to W.
- DIV, 12: clock cycles per UART bit (baud = clk / DIV); must be ≥ 4.
- clk  in  1  system clock.
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- rx_i  in  1  asynchronous UART line, idle high.
- in0, in1, in2, in3  out  W each  signed; last received input-channel values.
- out0, out1, out2, out3  out  W each  signed; last received output-channel values.
- frame_valid  out  1  one-cycle pulse; all eight channel outputs were updated this cycle.
- byte_o  out  8  last correctly framed byte (debug).
- byte_valid  out  1  one-cycle pulse with byte_o.
- err_count  out  8  saturating count of framing errors and payload aborts.

## Operation
- Line sampling:
  - rx_i passes through a 2-FF synchroniser.
  - Both flops reset to 1, so no false start is seen after reset.
- Bit receiver states: IDLE, START, DATA, STOP.
  - IDLE: a synchronised low moves to START and clears the bit timer.
  - START: at timer = DIV/2 (floor), the line is sampled.
    - High: false start; return to IDLE with no byte and no error.
    - Low: go to DATA with the timer reloaded.
  - DATA: sample every DIV cycles from the start-bit midpoint, 8 bits, LSB first.
  - STOP: sample one more bit DIV cycles later.
    - High: byte_o / byte_valid are issued.
    - Low: framing error; err_count increments, no byte is issued, and the parser is forced to HUNT1.
  - Either way, return to IDLE right after the stop-bit sample. The next start edge may be detected on the following cycle.
- Frame parser states: HUNT1, HUNT2, PAYLOAD. It advances only on byte_valid.
  - HUNT1: 0xBE → HUNT2; any other byte is ignored.
  - HUNT2: 0xEF → PAYLOAD with index 0; 0xBE → stay in HUNT2; anything else → HUNT1.
  - PAYLOAD: bytes fill a 16-byte shadow buffer, index 0..15.
    - Byte order is big-endian per channel (high byte first).
    - Channel order is in0, in1, in2, in3, out0, out1, out2, out3.
    - 0xBE/0xEF bytes inside the payload are data, not markers.
    - On byte index 15: copy the shadow buffer to the outputs, sign-extend to W, pulse frame_valid, go to HUNT1.
- Filler bytes between frames (the transmitter sends up to 7 repeats of the last byte) are discarded by HUNT1.
- Outputs only change on frame_valid. A partial or aborted frame never alters in0..out3.
- err_count saturates at 0xFF and is cleared only by rst.
- Reset: all channel outputs 0, frame_valid 0, byte_valid 0, byte_o 0, err_count 0, receiver IDLE, parser HUNT1, payload index 0. Reset mid-frame discards the partial frame; the outputs return to 0.

## Timing
- Start detection: 2 cycles of synchroniser latency after the rx_i falling edge.
- Sample points: start bit at DIV/2 cycles after detection; data bit k at DIV/2 + (k+1)·DIV; stop bit at DIV/2 + 9·DIV.
- byte_valid is high the cycle after the stop-bit sample.
- frame_valid is high the cycle after byte_valid of payload byte 15, and the channel outputs change in that same cycle.
- Throughput: accepts back-to-back bytes with zero idle bits between the stop bit and the next start bit. Baud tolerance is ±3% relative to DIV.
- A framing error and byte 15 cannot coincide: a framing error suppresses the byte, so no frame completes.

## Test plan
- Clean frame at DIV=12: BE EF, then 80 00 7F FF 00 01 FF FF 12 34 BE EF 00 00 AB CD. Required: in0=-32768, in1=32767, in2=1, in3=-1, out0=0x1234, out1=0xBEEF (signed), out2=0, out3=0xABCD (signed). One frame_valid pulse; err_count=0.
- Resync: garbage 00 BE 55 BE BE EF followed by a 16-byte payload. Required: exactly one frame_valid with the correct values.
- Framing error at payload byte 6 (stop bit held low), then a full good frame. Required: err_count=1; outputs unchanged until the good frame's frame_valid, then they match it.
- Glitch: rx_i low for DIV/2−2 cycles while idle. Required: no byte_valid, err_count=0.
- Reset asserted after payload byte 9, then a good frame. Required: outputs read 0 immediately after reset, then take the new frame's values; frame_valid count is 1.
- Continuous stream of 3 transmitter cycles (18-byte frame + 7 filler bytes, distinct values each, zero idle gap). Required: 3 frame_valid pulses, each carrying its frame's values; err_count=0.
